// File: rtl/riscv_pkg.sv
// Shared RV32 definitions: major opcodes and the hazard-stall FSM state encoding.
package riscv_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_AMO    = 7'b0101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    COOL = 2'd2
  } hazard_state_t;

endpackage

// File: rtl/hazard_stall_unit_if.sv
// ID/EX/MEM hazard inputs and the stall/bubble outputs of the hazard stall unit.
// No valid/ready handshake here: every signal is sampled each cycle as a level.
interface hazard_stall_unit_if #(
  parameter int REG_ADDR_W = 5,
  parameter int OPCODE_W   = 7
);
  logic [OPCODE_W-1:0]   opcode_id;
  logic [REG_ADDR_W-1:0] rs1_id;
  logic [REG_ADDR_W-1:0] rs2_id;
  logic [REG_ADDR_W-1:0] rd_ex;
  logic                  reg_write_ex;
  logic                  mem_read_ex;
  logic [REG_ADDR_W-1:0] rd_mem;
  logic                  mem_read_mem;
  logic                  stall;
  logic                  id_ex_flush;

  modport master (
    output opcode_id, rs1_id, rs2_id, rd_ex, reg_write_ex, mem_read_ex,
           rd_mem, mem_read_mem,
    input  stall, id_ex_flush
  );

  modport slave (
    input  opcode_id, rs1_id, rs2_id, rd_ex, reg_write_ex, mem_read_ex,
           rd_mem, mem_read_mem,
    output stall, id_ex_flush
  );
endinterface

// File: rtl/hazard_stall_unit_rs_usage_decode.sv
// Opcode to source-register usage decode; shared with the forwarding unit.
module rs_usage_decode
  import riscv_pkg::*;
#(
  parameter int OPCODE_W = 7
) (
  input  logic [OPCODE_W-1:0] opcode_i,
  output logic                rs1_used_o,
  output logic                rs2_used_o
);

  // JALR is left out on purpose: its target gets the operand via EX forwarding.
  always_comb begin
    rs1_used_o = 1'b0;
    rs2_used_o = 1'b0;
    case (opcode_i)
      OP_RTYPE, OP_BRANCH, OP_STORE, OP_AMO: begin
        rs1_used_o = 1'b1;
        rs2_used_o = 1'b1;
      end
      OP_ITYPE, OP_LOAD: rs1_used_o = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/hazard_stall_unit.sv
// ID-stage stall / ID-EX bubble generator with bounded 1- or 2-cycle stall runs.
// Optional perf counters under `HAZARD_STALL_PERF_EN.
module hazard_stall_unit
  import riscv_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int OPCODE_W   = 7,
  parameter int MAX_STALL  = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  hazard_stall_unit_if.slave   hz,
  output hazard_state_t        state_dbg_o
`ifdef HAZARD_STALL_PERF_EN
  ,
  output logic [31:0]          stall_cycles,
  output logic [15:0]          stall_h2_events
`endif
);

  if (MAX_STALL != 2) begin : g_max_stall_check
    $error("hazard_stall_unit only supports MAX_STALL == 2");
  end

  logic          rs1_used, rs2_used;
  logic          match_ex, match_mem, is_branch;
  logic          h1, h2, stall_c;
  hazard_state_t state_q, state_d;

  rs_usage_decode #(.OPCODE_W(OPCODE_W)) u_rs_usage_decode (
    .opcode_i   (hz.opcode_id),
    .rs1_used_o (rs1_used),
    .rs2_used_o (rs2_used)
  );

  function automatic logic rs_hit(input logic [REG_ADDR_W-1:0] rd,
                                  input logic [REG_ADDR_W-1:0] rs1,
                                  input logic [REG_ADDR_W-1:0] rs2,
                                  input logic u1, input logic u2);
    return (rd != '0) && ((u1 && rd == rs1) || (u2 && rd == rs2));
  endfunction

  assign match_ex  = hz.reg_write_ex &&
                     rs_hit(hz.rd_ex, hz.rs1_id, hz.rs2_id, rs1_used, rs2_used);
  assign match_mem = hz.mem_read_mem &&
                     rs_hit(hz.rd_mem, hz.rs1_id, hz.rs2_id, rs1_used, rs2_used);
  assign is_branch = (hz.opcode_id == OP_BRANCH);

  // Branch resolves in ID, so a load feeding it needs two bubbles; H2 wins over H1.
  assign h2 = is_branch && match_ex && hz.mem_read_ex;
  assign h1 = is_branch ? ((match_ex && !hz.mem_read_ex) || match_mem)
                        : (match_ex && hz.mem_read_ex);

  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    stall_c = 1'b0;
    case (state_q)
      IDLE: begin
        stall_c = h1 || h2;
        if (h2)      state_d = HOLD;
        else if (h1) state_d = COOL;
      end
      HOLD: begin
        stall_c = 1'b1;
        state_d = COOL;
      end
      COOL:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Reset masks the output at once so an aborted HOLD leaves no residual stall.
  assign hz.stall       = reset && stall_c;
  assign hz.id_ex_flush = hz.stall;
  assign state_dbg_o    = state_q;

`ifdef HAZARD_STALL_PERF_EN
  logic [31:0] stall_cycles_q;
  logic [15:0] stall_h2_events_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cycles_q    <= '0;
      stall_h2_events_q <= '0;
    end else begin
      if (hz.stall) stall_cycles_q <= stall_cycles_q + 32'd1;
      if (state_q == IDLE && state_d == HOLD)
        stall_h2_events_q <= stall_h2_events_q + 16'd1;
    end
  end

  assign stall_cycles    = stall_cycles_q;
  assign stall_h2_events = stall_h2_events_q;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Self-checking bench for hazard_stall_unit: vector table plus multi-cycle sequences.
module tb_hazard_stall_unit;
  import riscv_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hazard_stall_unit_if hz_if ();
  hazard_state_t state_dbg;
`ifdef HAZARD_STALL_PERF_EN
  logic [31:0] stall_cycles;
  logic [15:0] stall_h2_events;
`endif

  hazard_stall_unit dut (
    .clk         (clk),
    .reset       (reset),
    .hz          (hz_if),
    .state_dbg_o (state_dbg)
`ifdef HAZARD_STALL_PERF_EN
    ,
    .stall_cycles    (stall_cycles),
    .stall_h2_events (stall_h2_events)
`endif
  );

  typedef struct {
    logic [6:0] op;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd_ex;
    logic       rwe;
    logic       mre;
    logic [4:0] rd_mem;
    logic       mrm;
    int         run;
  } vec_t;

  // ---------------- scoreboard ----------------
  logic [1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;
  int exp_cycles = 0;
  int exp_h2 = 0;

  function automatic vec_t mk(input logic [6:0] op, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [4:0] rd_ex,
                              input logic rwe, input logic mre,
                              input logic [4:0] rd_mem, input logic mrm,
                              input int run);
    vec_t v;
    v.op = op; v.rs1 = rs1; v.rs2 = rs2; v.rd_ex = rd_ex; v.rwe = rwe;
    v.mre = mre; v.rd_mem = rd_mem; v.mrm = mrm; v.run = run;
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input vec_t v);
    hz_if.opcode_id    = v.op;
    hz_if.rs1_id       = v.rs1;
    hz_if.rs2_id       = v.rs2;
    hz_if.rd_ex        = v.rd_ex;
    hz_if.reg_write_ex = v.rwe;
    hz_if.mem_read_ex  = v.mre;
    hz_if.rd_mem       = v.rd_mem;
    hz_if.mem_read_mem = v.mrm;
  endtask

  task automatic expect_stall(input logic s, input logic h2_start);
    exp_q.push_back({s, s});
    if (reset && s) exp_cycles++;
    if (reset && h2_start) exp_h2++;
  endtask

  task automatic check(input string nm);
    logic [1:0] got, e;
    @(negedge clk);
    got = {hz_if.stall, hz_if.id_ex_flush};
    n_vec++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL %s: got stall/flush=%b but no expected entry queued", nm, got);
    end else begin
      e = exp_q.pop_front();
      if (got !== e) begin
        n_err++;
        $display("FAIL %s: stall/flush got %b required %b", nm, got, e);
      end
    end
  endtask

  task automatic check_state(input hazard_state_t s, input string nm);
    n_vec++;
    if (state_dbg !== s) begin
      n_err++;
      $display("FAIL %s: state got %0d required %0d", nm, state_dbg, s);
    end
  endtask

  task automatic cycle(input vec_t v, input logic s, input logic h2_start,
                       input string nm);
    @(posedge clk);
    #1;
    drive(v);
    expect_stall(s, h2_start);
    check(nm);
  endtask

  // ---------------- stimulus ----------------
  vec_t vecs[16];
  vec_t nop, h2v;

  initial begin
    nop = mk(OP_LUI, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 0);
    h2v = mk(OP_BRANCH, 5'd5, 5'd6, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 2);

    // {op, rs1, rs2, rd_ex, reg_write_ex, mem_read_ex, rd_mem, mem_read_mem, run}
    vecs[0]  = h2v;                                                              // LOAD x5 -> BEQ x5,x6
    vecs[1]  = mk(OP_BRANCH, 5'd7, 5'd0, 5'd7, 1'b1, 1'b0, 5'd0, 1'b0, 1);        // ADD x7 -> BNE x7,x0
    vecs[2]  = mk(OP_RTYPE,  5'd3, 5'd1, 5'd3, 1'b1, 1'b1, 5'd0, 1'b0, 1);        // load-use on rs1
    vecs[3]  = mk(OP_RTYPE,  5'd0, 5'd1, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 0);        // rd_ex = x0
    vecs[4]  = mk(OP_JALR,   5'd5, 5'd0, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 0);        // JALR after load
    vecs[5]  = mk(OP_JAL,    5'd5, 5'd5, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 0);        // JAL, any EX/MEM
    vecs[6]  = mk(OP_BRANCH, 5'd1, 5'd9, 5'd0, 1'b0, 1'b0, 5'd9, 1'b1, 1);        // branch, load in MEM
    vecs[7]  = mk(OP_RTYPE,  5'd1, 5'd9, 5'd0, 1'b0, 1'b0, 5'd9, 1'b1, 0);        // ALU, load in MEM
    vecs[8]  = mk(OP_STORE,  5'd2, 5'd8, 5'd8, 1'b1, 1'b1, 5'd0, 1'b0, 1);        // store rs2 load-use
    vecs[9]  = mk(OP_ITYPE,  5'd2, 5'd8, 5'd8, 1'b1, 1'b1, 5'd0, 1'b0, 0);        // rs2 field unused
    vecs[10] = mk(OP_BRANCH, 5'd4, 5'd1, 5'd4, 1'b0, 1'b0, 5'd0, 1'b0, 0);        // EX not writing
    vecs[11] = mk(OP_AMO,    5'd2, 5'd12, 5'd12, 1'b1, 1'b1, 5'd0, 1'b0, 1);      // AMO rs2 load-use
    vecs[12] = mk(OP_BRANCH, 5'd5, 5'd6, 5'd5, 1'b1, 1'b1, 5'd6, 1'b1, 2);        // EX+MEM loads, branch
    vecs[13] = mk(OP_LOAD,   5'd3, 5'd0, 5'd3, 1'b1, 1'b0, 5'd0, 1'b0, 0);        // ALU -> LOAD base
    vecs[14] = mk(OP_SYSTEM, 5'd3, 5'd3, 5'd3, 1'b1, 1'b1, 5'd3, 1'b1, 0);        // SYSTEM never stalls
    vecs[15] = mk(OP_BRANCH, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 0);        // x0 operands

    // Reset holds the outputs low even with an H2 pattern present.
    reset = 1'b0;
    drive(h2v);
    expect_stall(1'b0, 1'b0);
    check("reset_gate");
    @(posedge clk);
    #1;
    check_state(IDLE, "reset_state");
    reset = 1'b1;
    drive(nop);

    // Table: each vector from IDLE, then idle cycles to observe the full run.
    foreach (vecs[i]) begin
      cycle(vecs[i], vecs[i].run > 0, vecs[i].run == 2, $sformatf("vec%0d_c0", i));
      cycle(nop, vecs[i].run == 2, 1'b0, $sformatf("vec%0d_c1", i));
      cycle(nop, 1'b0, 1'b0, $sformatf("vec%0d_c2", i));
      cycle(nop, 1'b0, 1'b0, $sformatf("vec%0d_c3", i));
    end

    // H2 held for 5 cycles: 1,1,0,1,1.
    cycle(h2v, 1'b1, 1'b1, "hold5_c0");
    cycle(h2v, 1'b1, 1'b0, "hold5_c1");
    check_state(HOLD, "hold5_state_hold");
    cycle(h2v, 1'b0, 1'b0, "hold5_c2");
    check_state(COOL, "hold5_state_cool");
    cycle(h2v, 1'b1, 1'b1, "hold5_c3");
    cycle(h2v, 1'b1, 1'b0, "hold5_c4");
    cycle(nop, 1'b0, 1'b0, "hold5_c5");
    cycle(nop, 1'b0, 1'b0, "hold5_c6");

    // H1 held: 1,0,1,0.
    for (int k = 0; k < 4; k++)
      cycle(vecs[1], (k % 2) == 0, 1'b0, $sformatf("h1hold_c%0d", k));
    cycle(nop, 1'b0, 1'b0, "h1hold_tail");

    // Reset during HOLD aborts the run.
    cycle(h2v, 1'b1, 1'b1, "rst_h2_start");
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_cycles = 0;
    exp_h2 = 0;
    expect_stall(1'b0, 1'b0);
    check("rst_mid_hold");
    @(posedge clk);
    #1;
    check_state(IDLE, "rst_mid_hold_state");
    reset = 1'b1;
    drive(nop);
    expect_stall(1'b0, 1'b0);
    check("post_rst_c0");
    cycle(nop, 1'b0, 1'b0, "post_rst_c1");
    cycle(nop, 1'b0, 1'b0, "post_rst_c2");

    // Random short bursts of the two branch hazards, checked for run length.
    for (int k = 0; k < 6; k++) begin
      if ($urandom_range(0, 1) == 1) begin
        cycle(h2v, 1'b1, 1'b1, $sformatf("rnd%0d_h2_c0", k));
        cycle(nop, 1'b1, 1'b0, $sformatf("rnd%0d_h2_c1", k));
      end else begin
        cycle(vecs[1], 1'b1, 1'b0, $sformatf("rnd%0d_h1_c0", k));
        cycle(nop, 1'b0, 1'b0, $sformatf("rnd%0d_h1_c1", k));
      end
      cycle(nop, 1'b0, 1'b0, $sformatf("rnd%0d_c2", k));
      cycle(nop, 1'b0, 1'b0, $sformatf("rnd%0d_c3", k));
    end

    @(posedge clk);
    #1;
`ifdef HAZARD_STALL_PERF_EN
    n_vec++;
    if (stall_cycles !== 32'(exp_cycles)) begin
      n_err++;
      $display("FAIL perf_stall_cycles: got %0d required %0d", stall_cycles, exp_cycles);
    end
    n_vec++;
    if (stall_h2_events !== 16'(exp_h2)) begin
      n_err++;
      $display("FAIL perf_h2_events: got %0d required %0d", stall_h2_events, exp_h2);
    end
`endif
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: %0d expected entries left, required 0", exp_q.size());
    end

    // ---------------- report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
